// File: rtl/isp_ctrl.sv
// Frame/line sequencer for the debayer datapath: gates pixel strobes, primes, streams and drains lines.
// Optional frame counter: define ISP_CTRL_FRAME_CNT_EN.
//
// state     | meaning
// WAIT_FS   | idle, waiting for frame start (and en)
// PRIME     | filling the first PRIME_LINES lines, rgb_valid low
// STREAM    | pixels accepted and RGB output enabled
// DRAIN     | no input; emitting the last buffered line
module isp_ctrl #(
   parameter int LINE_LENGTH = 640,
   parameter int NUM_LINES   = 480,
   parameter int PRIME_LINES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        fs_in,
   input  logic        fe_in,
   input  logic        px_valid,
   input  logic        reading,
   input  logic        err_clr,
   output logic        data_valid,
   output logic        rgb_valid,
   output logic        sol,
   output logic        eol,
   output logic [15:0] line_cnt,
   output logic [15:0] px_cnt,
   output logic        frame_active,
   output logic        err_short,
   output logic        err_long,
   output logic        err_sync,
   output logic [15:0] frame_cnt
);

   localparam logic [1:0]  ST_WAIT_FS = 2'd0;
   localparam logic [1:0]  ST_PRIME   = 2'd1;
   localparam logic [1:0]  ST_STREAM  = 2'd2;
   localparam logic [1:0]  ST_DRAIN   = 2'd3;
   localparam logic [15:0] LAST_PX    = 16'(LINE_LENGTH - 1);
   localparam logic [15:0] LINES_MAX  = 16'(NUM_LINES);
   localparam logic [1:0]  PRIME_LAST = 2'(PRIME_LINES - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] line_cnt_q, line_cnt_d;
   logic [15:0] px_cnt_q, px_cnt_d;
   logic [15:0] drain_cnt_q, drain_cnt_d;
   logic [1:0]  prime_cnt_q, prime_cnt_d;
   logic        rgb_valid_q, rgb_valid_d;
   logic        sol_q, sol_d;
   logic        eol_q, eol_d;
   logic        err_short_q, err_short_d;
   logic        err_long_q, err_long_d;
   logic        err_sync_q, err_sync_d;

   logic in_frame, room, accept, fe_end, short_cond, drain_done;
   logic set_short, set_long, set_sync, start;

   assign in_frame   = (state_q == ST_PRIME) || (state_q == ST_STREAM);
   assign room       = line_cnt_q < LINES_MAX;
   assign accept     = px_valid & in_frame & room;
   assign fe_end     = fe_in & in_frame;
   assign short_cond = (px_cnt_q != 16'd0) || (line_cnt_q != LINES_MAX);
   assign drain_done = (state_q == ST_DRAIN) & reading & (drain_cnt_q == LAST_PX);

   always_comb begin
      state_d     = state_q;
      line_cnt_d  = line_cnt_q;
      px_cnt_d    = px_cnt_q;
      drain_cnt_d = drain_cnt_q;
      prime_cnt_d = prime_cnt_q;
      rgb_valid_d = rgb_valid_q;
      sol_d       = 1'b0;
      eol_d       = 1'b0;
      set_short   = 1'b0;
      set_long    = px_valid & in_frame & ~room;
      set_sync    = 1'b0;
      start       = 1'b0;

      if (accept) begin
         sol_d = (px_cnt_q == 16'd0);
         if (px_cnt_q == LAST_PX) begin
            px_cnt_d   = 16'd0;
            line_cnt_d = line_cnt_q + 16'd1;
            eol_d      = 1'b1;
         end else begin
            px_cnt_d = px_cnt_q + 16'd1;
         end
      end

      case (state_q)
         ST_PRIME: begin
            if (eol_q) begin
               if (prime_cnt_q == PRIME_LAST) begin
                  state_d     = ST_STREAM;
                  rgb_valid_d = 1'b1;
               end else begin
                  prime_cnt_d = prime_cnt_q + 2'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_done) begin
               state_d     = ST_WAIT_FS;
               rgb_valid_d = 1'b0;
            end else if (reading) begin
               drain_cnt_d = drain_cnt_q + 16'd1;
            end
         end
         default: ;
      endcase

      // Frame end is resolved before frame start so a coincident fs is not a resync.
      if (fe_end) begin
         px_cnt_d = 16'd0;
         sol_d    = 1'b0;
         eol_d    = 1'b0;
         if (state_q == ST_PRIME) begin
            state_d     = ST_WAIT_FS;
            rgb_valid_d = 1'b0;
            set_short   = 1'b1;
         end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 16'd0;
            rgb_valid_d = 1'b1;
            set_short   = short_cond;
         end
      end

      if (fs_in) begin
         if ((state_q == ST_WAIT_FS) || fe_end) begin
            if (en) begin
               start = 1'b1;
            end else if (fe_end) begin
               state_d     = ST_WAIT_FS;
               rgb_valid_d = 1'b0;
            end
         end else begin
            set_sync = 1'b1;
            start    = 1'b1;
         end
      end

      if (start) begin
         state_d     = ST_PRIME;
         line_cnt_d  = 16'd0;
         px_cnt_d    = 16'd0;
         prime_cnt_d = 2'd0;
         rgb_valid_d = 1'b0;
         sol_d       = 1'b0;
         eol_d       = 1'b0;
      end

      err_short_d = (err_short_q & ~err_clr) | set_short;
      err_long_d  = (err_long_q  & ~err_clr) | set_long;
      err_sync_d  = (err_sync_q  & ~err_clr) | set_sync;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT_FS;
         line_cnt_q  <= 16'd0;
         px_cnt_q    <= 16'd0;
         drain_cnt_q <= 16'd0;
         prime_cnt_q <= 2'd0;
         rgb_valid_q <= 1'b0;
         sol_q       <= 1'b0;
         eol_q       <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         err_sync_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_cnt_q  <= line_cnt_d;
         px_cnt_q    <= px_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         prime_cnt_q <= prime_cnt_d;
         rgb_valid_q <= rgb_valid_d;
         sol_q       <= sol_d;
         eol_q       <= eol_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         err_sync_q  <= err_sync_d;
      end
   end

`ifdef ISP_CTRL_FRAME_CNT_EN
   logic        frame_bad_q, frame_bad_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // frame_bad remembers whether this frame's own fe was short, independent of err_clr.
   always_comb begin
      frame_bad_d = frame_bad_q;
      frame_cnt_d = frame_cnt_q;
      if (fe_end) frame_bad_d = set_short;
      if ((state_q == ST_DRAIN) && (state_d == ST_WAIT_FS) && !frame_bad_q)
         frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_bad_q <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         frame_bad_q <= frame_bad_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

   assign data_valid   = accept;
   assign rgb_valid    = rgb_valid_q;
   assign sol          = sol_q;
   assign eol          = eol_q;
   assign line_cnt     = line_cnt_q;
   assign px_cnt       = px_cnt_q;
   assign frame_active = (state_q != ST_WAIT_FS);
   assign err_short    = err_short_q;
   assign err_long     = err_long_q;
   assign err_sync     = err_sync_q;

endmodule
